planificador_llamadas: RTL and testbench

- Call scheduler for the elevator car controller (prueba_2_asc family).
- Latches floor calls (floors -1, 1, 2, 3) into a pending mask and applies a SCAN policy: keep the current sweep direction while calls remain ahead, otherwise reverse.
- Drives the car's 3-bit destino and holds it stable until the car reports arrival via its ocupado handshake.
- Sits between the call buttons and the car controller.

---
 rtl/planificador_llamadas_pkg.sv | 32 +++
 rtl/planificador_llamadas_if.sv | 24 ++
 rtl/planificador_llamadas_selector_scan.sv | 67 ++++++
 rtl/planificador_llamadas.sv | 125 ++++++++++++
 tb/tb_planificador_llamadas.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/planificador_llamadas_pkg.sv
// Shared encodings for the elevator call scheduler: floor codes, the idle
// destination code, FSM state constants and the floor-to-mask helper.
package planificador_pkg;

  typedef logic [1:0] piso_t;
  typedef logic [3:0] mascara_t;

  localparam piso_t MENOS_UNO = 2'b00;
  localparam piso_t UNO       = 2'b01;
  localparam piso_t DOS       = 2'b10;
  localparam piso_t TRES      = 2'b11;

  localparam logic [2:0] DESTINO_NADA = 3'b100;

  localparam logic [1:0] ESPERA     = 2'd0;
  localparam logic [1:0] ASIGNAR    = 2'd1;
  localparam logic [1:0] ESPERA_ACK = 2'd2;
  localparam logic [1:0] EN_CURSO   = 2'd3;

  function automatic mascara_t bit_piso(input piso_t p);
    mascara_t m;
    case (p)
      MENOS_UNO: m = 4'b0001;
      UNO:       m = 4'b0010;
      DOS:       m = 4'b0100;
      TRES:      m = 4'b1000;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/planificador_llamadas_if.sv
// Bundle between call buttons / car controller and the scheduler.
// master is the scheduler side, slave is the car/button side.
interface planificador_llamadas_if;
  import planificador_pkg::*;

  mascara_t   llamada;
  piso_t      piso;
  logic       ocupado;
  logic [2:0] destino;
  mascara_t   pendientes;
  logic       sentido;
  logic       fallo;

  modport master (
    input  llamada, piso, ocupado,
    output destino, pendientes, sentido, fallo
  );

  modport slave (
    output llamada, piso, ocupado,
    input  destino, pendientes, sentido, fallo
  );

endinterface

// File: rtl/planificador_llamadas_selector_scan.sv
// SCAN target selector: nearest pending floor ahead in the sweep direction,
// falling back to the nearest one behind (which requests a reversal).
module selector_scan
  import planificador_pkg::*;
(
  input  mascara_t pendientes,
  input  piso_t    piso,
  input  logic     sentido,
  output piso_t    objetivo,
  output logic     hay_objetivo,
  output logic     invertir,
  output logic     es_local
);

  piso_t arriba;
  piso_t abajo;
  logic  arriba_ok;
  logic  abajo_ok;

  // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
  always_comb begin
    arriba    = MENOS_UNO;
    arriba_ok = 1'b0;
    abajo     = MENOS_UNO;
    abajo_ok  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (pendientes[i] && (piso_t'(i) > piso)) begin
        arriba    = piso_t'(i);
        arriba_ok = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pendientes[i] && (piso_t'(i) < piso)) begin
        abajo    = piso_t'(i);
        abajo_ok = 1'b1;
      end
    end
  end

  always_comb begin
    objetivo     = MENOS_UNO;
    hay_objetivo = 1'b0;
    invertir     = 1'b0;
    if (sentido) begin
      if (arriba_ok) begin
        objetivo     = arriba;
        hay_objetivo = 1'b1;
      end else if (abajo_ok) begin
        objetivo     = abajo;
        hay_objetivo = 1'b1;
        invertir     = 1'b1;
      end
    end else begin
      if (abajo_ok) begin
        objetivo     = abajo;
        hay_objetivo = 1'b1;
      end else if (arriba_ok) begin
        objetivo     = arriba;
        hay_objetivo = 1'b1;
        invertir     = 1'b1;
      end
    end
  end

  assign es_local = (pendientes == bit_piso(piso));

endmodule

// File: rtl/planificador_llamadas.sv
// Elevator call scheduler: latches floor calls, picks the next floor with a
// SCAN policy and holds destino until the car acknowledges and arrives.
module planificador_llamadas
  import planificador_pkg::*;
#(
  parameter int T_ACK = 16,
  parameter int CTR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  planificador_llamadas_if.master bus
);

  logic [1:0]       estado;
  logic [1:0]       estado_sig;
  piso_t            objetivo_r;
  logic [CTR_W-1:0] cnt_ack;
  logic             ocupado_d;
  logic [2:0]       destino_r;
  mascara_t         pend_r;
  logic             sentido_r;
  logic             fallo_r;

  piso_t    sel_objetivo;
  logic     sel_hay;
  logic     sel_invertir;
  logic     sel_local;
  mascara_t clr;
  logic     timeout;
  logic     asigna;
  logic     caida;

  selector_scan u_selector (
    .pendientes  (pend_r),
    .piso        (bus.piso),
    .sentido     (sentido_r),
    .objetivo    (sel_objetivo),
    .hay_objetivo(sel_hay),
    .invertir    (sel_invertir),
    .es_local    (sel_local)
  );

  assign caida = ocupado_d && !bus.ocupado;

  // A new destino is never issued while the car reports busy, so it stays stable under ocupado.
  assign asigna = (estado == ASIGNAR) && sel_hay && !bus.ocupado;

  always_comb begin
    estado_sig = estado;
    clr        = '0;
    timeout    = 1'b0;
    case (estado)
      ESPERA: begin
        if (sel_local && !bus.ocupado) begin
          clr = bit_piso(bus.piso);
        end else if (sel_hay && !bus.ocupado) begin
          estado_sig = ASIGNAR;
        end
      end
      ASIGNAR: begin
        estado_sig = asigna ? ESPERA_ACK : ESPERA;
      end
      ESPERA_ACK: begin
        if (bus.ocupado) begin
          estado_sig = EN_CURSO;
        end else if (bus.piso == objetivo_r) begin
          clr        = bit_piso(objetivo_r);
          estado_sig = ESPERA;
        end else if (cnt_ack == CTR_W'(T_ACK - 1)) begin
          timeout    = 1'b1;
          estado_sig = ESPERA;
        end
      end
      EN_CURSO: begin
        if (caida) begin
          if (bus.piso == objetivo_r) begin
            clr        = bit_piso(objetivo_r);
            estado_sig = ESPERA;
          end else begin
            estado_sig = ASIGNAR;
          end
        end
      end
      default: estado_sig = ESPERA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= ESPERA;
      objetivo_r <= MENOS_UNO;
      cnt_ack    <= '0;
      ocupado_d  <= 1'b0;
      destino_r  <= DESTINO_NADA;
      pend_r     <= '0;
      sentido_r  <= 1'b1;
      fallo_r    <= 1'b0;
    end else begin
      estado    <= estado_sig;
      ocupado_d <= bus.ocupado;
      // Clear wins over a call arriving for the same floor in the same cycle.
      pend_r    <= (pend_r | bus.llamada) & ~clr;
      if (asigna) begin
        objetivo_r <= sel_objetivo;
        destino_r  <= {1'b0, sel_objetivo};
        cnt_ack    <= '0;
        if (sel_invertir) begin
          sentido_r <= ~sentido_r;
        end
      end else if (estado == ESPERA_ACK && !bus.ocupado) begin
        cnt_ack <= cnt_ack + 1'b1;
      end
      if (timeout) begin
        fallo_r   <= 1'b1;
        destino_r <= DESTINO_NADA;
      end
    end
  end

  assign bus.destino    = destino_r;
  assign bus.pendientes = pend_r;
  assign bus.sentido    = sentido_r;
  assign bus.fallo      = fallo_r;

endmodule

// File: tb/tb_planificador_llamadas.sv
// Bench for planificador_llamadas: directed scenarios with literal expectations,
// then randomized calls and car behaviour checked every cycle against a reference model.
module tb_planificador_llamadas;

  localparam int T_ACK = 16;
  localparam int CTR_W = 5;

  localparam int F_REPOSO = 0;
  localparam int F_ELIGE  = 1;
  localparam int F_ACK    = 2;
  localparam int F_VIAJE  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  planificador_llamadas_if bus();

  planificador_llamadas #(.T_ACK(T_ACK), .CTR_W(CTR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_pend;
  logic [2:0] m_dest;
  logic       m_sent;
  logic       m_fallo;
  int         m_fase;
  int         m_obj;
  int         m_esp;
  logic       m_ocup_prev;
  bit         arrancado = 0;

  task automatic chk(input string nombre, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nombre, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Nearest pending floor in the sweep direction, else nearest behind (reversal).
  function automatic int elegir(input logic [3:0] p, input int f, input bit arriba, output bit inv);
    int ade;
    int atr;
    ade = -1;
    atr = -1;
    inv = 1'b0;
    if (arriba) begin
      for (int i = f + 1; i < 4; i++) if (p[i] && ade < 0) ade = i;
      for (int i = f - 1; i >= 0; i--) if (p[i] && atr < 0) atr = i;
    end else begin
      for (int i = f - 1; i >= 0; i--) if (p[i] && ade < 0) ade = i;
      for (int i = f + 1; i < 4; i++) if (p[i] && atr < 0) atr = i;
    end
    if (ade >= 0) return ade;
    if (atr >= 0) begin
      inv = 1'b1;
      return atr;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] clr;
    logic [3:0] uno;
    int         pf;
    int         t;
    bit         inv;
    arrancado = 1;
    if (rst) begin
      m_pend      = 4'b0000;
      m_dest      = 3'b100;
      m_sent      = 1'b1;
      m_fallo     = 1'b0;
      m_fase      = F_REPOSO;
      m_obj       = 0;
      m_esp       = 0;
      m_ocup_prev = 1'b0;
    end else begin
      clr = 4'b0000;
      uno = 4'b0001;
      pf  = int'(bus.piso);
      t   = elegir(m_pend, pf, m_sent, inv);
      case (m_fase)
        F_REPOSO: begin
          if (m_pend == (uno << pf) && !bus.ocupado) clr[pf] = 1'b1;
          else if (t >= 0 && !bus.ocupado) m_fase = F_ELIGE;
        end
        F_ELIGE: begin
          if (t >= 0 && !bus.ocupado) begin
            m_obj  = t;
            m_dest = {1'b0, 2'(t)};
            if (inv) m_sent = !m_sent;
            m_esp  = 0;
            m_fase = F_ACK;
          end else begin
            m_fase = F_REPOSO;
          end
        end
        F_ACK: begin
          if (bus.ocupado) begin
            m_fase = F_VIAJE;
          end else if (pf == m_obj) begin
            clr[m_obj] = 1'b1;
            m_fase     = F_REPOSO;
          end else begin
            m_esp++;
            if (m_esp == T_ACK) begin
              m_fallo = 1'b1;
              m_dest  = 3'b100;
              m_fase  = F_REPOSO;
            end
          end
        end
        default: begin
          if (m_ocup_prev && !bus.ocupado) begin
            if (pf == m_obj) begin
              clr[m_obj] = 1'b1;
              m_fase     = F_REPOSO;
            end else begin
              m_fase = F_ELIGE;
            end
          end
        end
      endcase
      m_pend      = (m_pend | bus.llamada) & ~clr;
      m_ocup_prev = bus.ocupado;
    end
  end

  always @(negedge clk) begin
    if (arrancado) begin
      chk("destino", 8'(bus.destino), 8'(m_dest));
      chk("pendientes", 8'(bus.pendientes), 8'(m_pend));
      chk("sentido", 8'(bus.sentido), 8'(m_sent));
      chk("fallo", 8'(bus.fallo), 8'(m_fallo));
    end
  end

  // Car arrives at floor f: busy for two cycles, then drops ocupado at f.
  task automatic servir(input logic [1:0] f);
    bus.ocupado = 1'b1;
    tick();
    bus.piso = f;
    tick();
    bus.ocupado = 1'b0;
    tick();
  endtask

  initial begin
    bit viaja;
    bit atascado;
    int resto;
    rst         = 1'b1;
    bus.llamada = 4'b0000;
    bus.piso    = 2'b11;
    bus.ocupado = 1'b0;
    viaja       = 0;
    atascado    = 0;
    resto       = 0;
    tick();
    tick();
    chk("rst_destino", 8'(bus.destino), 8'h04);
    chk("rst_pendientes", 8'(bus.pendientes), 8'h00);
    chk("rst_sentido", 8'(bus.sentido), 8'h01);
    chk("rst_fallo", 8'(bus.fallo), 8'h00);

    // Single call to floor -1 from floor 3
    rst = 1'b0;
    bus.llamada = 4'b0001;
    tick();
    bus.llamada = 4'b0000;
    chk("s1_latch", 8'(bus.pendientes), 8'h01);
    tick();
    tick();
    chk("s1_destino", 8'(bus.destino), 8'h00);
    chk("s1_sentido", 8'(bus.sentido), 8'h00);
    servir(2'b00);
    chk("s1_clear", 8'(bus.pendientes), 8'h00);
    chk("s1_parked", 8'(bus.destino), 8'h00);

    // SCAN order and hold from floor 1 going up
    rst = 1'b1;
    bus.piso = 2'b01;
    tick();
    rst = 1'b0;
    bus.llamada = 4'b1001;
    tick();
    bus.llamada = 4'b0000;
    tick();
    tick();
    chk("s2_first", 8'(bus.destino), 8'h03);
    chk("s2_sentido_up", 8'(bus.sentido), 8'h01);
    bus.ocupado = 1'b1;
    tick();
    bus.llamada = 4'b0100;
    tick();
    bus.llamada = 4'b0000;
    chk("hold_pend", 8'(bus.pendientes), 8'h0d);
    chk("hold_destino", 8'(bus.destino), 8'h03);
    bus.piso = 2'b11;
    tick();
    bus.ocupado = 1'b0;
    tick();
    chk("s2_clear3", 8'(bus.pendientes), 8'h05);
    tick();
    tick();
    chk("s2_second", 8'(bus.destino), 8'h02);
    chk("s2_sentido_down", 8'(bus.sentido), 8'h00);
    servir(2'b10);
    chk("s2_clear2", 8'(bus.pendientes), 8'h01);
    tick();
    tick();
    chk("s2_third", 8'(bus.destino), 8'h00);
    servir(2'b00);
    chk("s2_empty", 8'(bus.pendientes), 8'h00);

    // Local call at the car's own floor
    bus.piso = 2'b10;
    bus.llamada = 4'b0100;
    tick();
    bus.llamada = 4'b0000;
    chk("local_latch", 8'(bus.pendientes), 8'h04);
    tick();
    chk("local_clear", 8'(bus.pendientes), 8'h00);
    chk("local_destino", 8'(bus.destino), 8'h00);

    // Ack timeout and reissue
    bus.piso = 2'b11;
    bus.llamada = 4'b0010;
    tick();
    bus.llamada = 4'b0000;
    tick();
    tick();
    chk("to_destino", 8'(bus.destino), 8'h01);
    repeat (T_ACK - 1) tick();
    chk("to_before", 8'(bus.fallo), 8'h00);
    tick();
    chk("to_fallo", 8'(bus.fallo), 8'h01);
    chk("to_nada", 8'(bus.destino), 8'h04);
    chk("to_kept", 8'(bus.pendientes), 8'h02);
    tick();
    tick();
    chk("to_reissue", 8'(bus.destino), 8'h01);
    servir(2'b01);
    chk("to_served", 8'(bus.pendientes), 8'h00);
    chk("to_sticky", 8'(bus.fallo), 8'h01);

    // Reset during travel
    bus.llamada = 4'b1010;
    tick();
    bus.llamada = 4'b0000;
    tick();
    tick();
    chk("mr_destino", 8'(bus.destino), 8'h03);
    bus.ocupado = 1'b1;
    tick();
    chk("mr_pend", 8'(bus.pendientes), 8'h0a);
    rst = 1'b1;
    tick();
    chk("mr_pend0", 8'(bus.pendientes), 8'h00);
    chk("mr_nada", 8'(bus.destino), 8'h04);
    chk("mr_sentido", 8'(bus.sentido), 8'h01);
    chk("mr_fallo", 8'(bus.fallo), 8'h00);
    rst = 1'b0;
    bus.ocupado = 1'b0;
    tick();

    // Randomized calls with a loosely behaved car
    for (int c = 0; c < 4000; c++) begin
      bus.llamada = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst = ($urandom_range(0, 499) == 0);
      if (!viaja) begin
        if ($urandom_range(0, 199) == 0) atascado = !atascado;
        if (!atascado && m_dest != 3'b100 && m_dest[1:0] != bus.piso && $urandom_range(0, 3) == 0) begin
          viaja = 1;
          resto = $urandom_range(1, 6);
          bus.ocupado = 1'b1;
        end else if ($urandom_range(0, 63) == 0) begin
          bus.piso = 2'($urandom_range(0, 3));
        end
      end else begin
        resto--;
        if (resto <= 0) begin
          bus.piso = ($urandom_range(0, 7) != 0) ? m_dest[1:0] : 2'($urandom_range(0, 3));
          bus.ocupado = 1'b0;
          viaja = 0;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
